// File: rtl/bus_copy_engine_if.sv
// IO-interface bundle between the copy engine (initiator) and the system bus.
// The master side drives requests; the slave side answers them.
interface bus_copy_engine_if;
   logic [31:0] rw_address;
   logic [31:0] read_data;
   logic        read_request;
   logic        read_response;
   logic [31:0] write_data;
   logic [3:0]  write_strobe;
   logic        write_request;
   logic        write_response;

   modport master (
      output rw_address,
      output read_request,
      output write_data,
      output write_strobe,
      output write_request,
      input  read_data,
      input  read_response,
      input  write_response
   );

   modport slave (
      input  rw_address,
      input  read_request,
      input  write_data,
      input  write_strobe,
      input  write_request,
      output read_data,
      output read_response,
      output write_response
   );
endinterface

// File: rtl/bus_copy_engine.sv
// Word-copy engine: reads one word, writes it back at the destination, repeats.
// Every bus output is a flop, so the IO interface sees glitch-free requests.
module bus_copy_engine #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [31:0]       src_address,
   input  logic [31:0]       dst_address,
   input  logic [31:0]       word_count,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [31:0]       words_remaining,
   bus_copy_engine_if.master bus
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_GAP_R = 3'd2,
      ST_WRITE = 3'd3,
      ST_GAP_W = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      src_ptr_q, src_ptr_d;
   logic [31:0]      dst_ptr_q, dst_ptr_d;
   logic [31:0]      data_buf_q, data_buf_d;
   logic [31:0]      words_remaining_q, words_remaining_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             error_q, error_d;
   logic [31:0]      rw_address_q, rw_address_d;
   logic             read_request_q, read_request_d;
   logic [31:0]      write_data_q, write_data_d;
   logic [3:0]       write_strobe_q, write_strobe_d;
   logic             write_request_q, write_request_d;

   // Word alignment discards the byte-offset bits of both addresses.
   logic unused_addr_bits_s;
   assign unused_addr_bits_s = ^{src_address[1:0], dst_address[1:0]};

   // Next-state and next-output computation for the copy sequencer.
   always_comb begin
      state_d           = state_q;
      src_ptr_d         = src_ptr_q;
      dst_ptr_d         = dst_ptr_q;
      data_buf_d        = data_buf_q;
      words_remaining_d = words_remaining_q;
      wait_cnt_d        = wait_cnt_q;
      error_d           = error_q;
      done_d            = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               error_d           = 1'b0;
               words_remaining_d = word_count;
               if (word_count != 32'd0) begin
                  src_ptr_d  = {src_address[31:2], 2'b00};
                  dst_ptr_d  = {dst_address[31:2], 2'b00};
                  wait_cnt_d = '0;
                  state_d    = ST_READ;
               end else begin
                  done_d = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_READ: begin
            // abort beats a same-edge response; a response beats the timeout.
            if (abort) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else if (bus.read_response && read_request_q) begin
               data_buf_d = bus.read_data;
               src_ptr_d  = src_ptr_q + 32'd4;
               state_d    = ST_GAP_R;
            end else if (wait_cnt_q == CNT_LAST) begin
               error_d = 1'b1;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         ST_GAP_R: begin
            if (abort) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               wait_cnt_d = '0;
               state_d    = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (abort) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else if (bus.write_response && write_request_q) begin
               dst_ptr_d         = dst_ptr_q + 32'd4;
               words_remaining_d = words_remaining_q - 32'd1;
               state_d           = ST_GAP_W;
            end else if (wait_cnt_q == CNT_LAST) begin
               error_d = 1'b1;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         ST_GAP_W: begin
            if (abort || (words_remaining_q == 32'd0)) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               wait_cnt_d = '0;
               state_d    = ST_READ;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Bus outputs follow the state being entered, so they are registered.
      busy_d          = (state_d != ST_IDLE);
      read_request_d  = (state_d == ST_READ);
      write_request_d = (state_d == ST_WRITE);
      if (state_d == ST_READ) begin
         rw_address_d = src_ptr_d;
      end else if (state_d == ST_WRITE) begin
         rw_address_d = dst_ptr_d;
      end else begin
         rw_address_d = 32'd0;
      end
      write_data_d   = write_request_d ? data_buf_d : 32'd0;
      write_strobe_d = write_request_d ? 4'b1111 : 4'b0000;
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q           <= ST_IDLE;
         src_ptr_q         <= 32'd0;
         dst_ptr_q         <= 32'd0;
         data_buf_q        <= 32'd0;
         words_remaining_q <= 32'd0;
         wait_cnt_q        <= '0;
         busy_q            <= 1'b0;
         done_q            <= 1'b0;
         error_q           <= 1'b0;
         rw_address_q      <= 32'd0;
         read_request_q    <= 1'b0;
         write_data_q      <= 32'd0;
         write_strobe_q    <= 4'b0000;
         write_request_q   <= 1'b0;
      end else begin
         state_q           <= state_d;
         src_ptr_q         <= src_ptr_d;
         dst_ptr_q         <= dst_ptr_d;
         data_buf_q        <= data_buf_d;
         words_remaining_q <= words_remaining_d;
         wait_cnt_q        <= wait_cnt_d;
         busy_q            <= busy_d;
         done_q            <= done_d;
         error_q           <= error_d;
         rw_address_q      <= rw_address_d;
         read_request_q    <= read_request_d;
         write_data_q      <= write_data_d;
         write_strobe_q    <= write_strobe_d;
         write_request_q   <= write_request_d;
      end
   end

   assign busy              = busy_q;
   assign done              = done_q;
   assign error             = error_q;
   assign words_remaining   = words_remaining_q;
   assign bus.rw_address    = rw_address_q;
   assign bus.read_request  = read_request_q;
   assign bus.write_data    = write_data_q;
   assign bus.write_strobe  = write_strobe_q;
   assign bus.write_request = write_request_q;

endmodule
